// File: rtl/serial_tx_arbiter_pkg.sv
// Shared definitions for the serial transmit arbiter: default word width and FSM encoding.
package serial_tx_arbiter_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/serial_tx_arbiter_rr_pick.sv
// Round-robin pick: the first set request bit searching upward from last+1, wrapping.
module serial_tx_arbiter_rr_pick #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2
) (
    input  logic [NUM_CH-1:0]  req,
    input  logic [CH_BITS-1:0] last,
    output logic               any,
    output logic [CH_BITS-1:0] pick
);

    logic [CH_BITS-1:0] w_idx;

    // Offset NUM_CH brings the search back to last itself, so a lone requester is re-granted.
    always_comb begin
        any   = 1'b0;
        pick  = '0;
        w_idx = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = CH_BITS'((int'(last) + k) % NUM_CH);
            if (!any && req[w_idx]) begin
                any  = 1'b1;
                pick = w_idx;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serializer between NUM_CH byte sources;
// latches the granted byte, offers it on the parallel side, then acks the source.
module serial_tx_arbiter
    import serial_tx_arbiter_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH-1:0]       ch_full,
    input  logic [NUM_CH*WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]       ch_ack,
    output logic [WIDTH-1:0]        par_data,
    output logic                    par_ready,
    input  logic                    par_strobe,
    output logic                    busy,
    output logic [CH_BITS-1:0]      grant_ch
);

    state_t             r_state;
    logic [NUM_CH-1:0]  r_ack;
    logic [WIDTH-1:0]   r_data;
    logic               r_ready;
    logic               r_busy;
    logic [CH_BITS-1:0] r_grant;

    logic [NUM_CH-1:0]  w_req;
    logic               w_any;
    logic [CH_BITS-1:0] w_pick;
    logic [WIDTH-1:0]   w_slice [NUM_CH];

    assign w_req = ch_full & ch_enable;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slice
        assign w_slice[i] = ch_data[i*WIDTH +: WIDTH];
    end

    serial_tx_arbiter_rr_pick #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_rr_pick (
        .req  (w_req),
        .last (r_grant),
        .any  (w_any),
        .pick (w_pick)
    );

    // Arbitration only happens in S_IDLE, so the acked source has dropped full before the next decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ack   <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_grant <= CH_BITS'(NUM_CH - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= '0;
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_data  <= w_slice[w_pick];
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_OFFER;
                    end else begin
                        r_data  <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_OFFER: begin
                    if (par_strobe) begin
                        r_ready        <= 1'b0;
                        r_ack[r_grant] <= 1'b1;
                        r_state        <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_ack   <= '0;
                    r_data  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ch_ack    = r_ack;
    assign par_data  = r_data;
    assign par_ready = r_ready;
    assign busy      = r_busy;
    assign grant_ch  = r_grant;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter; the bench plays both the sources and the serializer handshake.
module tb_serial_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  ch_enable;
    logic [3:0]  ch_full;
    logic [31:0] ch_data;
    logic [3:0]  ch_ack;
    logic [7:0]  par_data;
    logic        par_ready;
    logic        par_strobe;
    logic        busy;
    logic [1:0]  grant_ch;

    int n_vec = 0;
    int n_err = 0;

    serial_tx_arbiter #(
        .NUM_CH  (4),
        .CH_BITS (2),
        .WIDTH   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_enable  (ch_enable),
        .ch_full    (ch_full),
        .ch_data    (ch_data),
        .ch_ack     (ch_ack),
        .par_data   (par_data),
        .par_ready  (par_ready),
        .par_strobe (par_strobe),
        .busy       (busy),
        .grant_ch   (grant_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Assert reset at a negedge, check the asynchronous clear, release two cycles later.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_ready", {31'd0, par_ready}, 32'd0);
        chk("rst_ack",   {28'd0, ch_ack},    32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_grant", {30'd0, grant_ch},  32'd3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait for an offer, check it, mimic the serializer strobe, check the one-cycle ack.
    task automatic serve(input int ch, input logic [7:0] d, input bit clr);
        int n;
        n = 0;
        while (par_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("offer_ready", {31'd0, par_ready}, 32'd1);
        chk("offer_grant", {30'd0, grant_ch},  32'(ch));
        chk("offer_data",  {24'd0, par_data},  {24'd0, d});
        chk("offer_busy",  {31'd0, busy},      32'd1);
        @(negedge clk);
        chk("offer_hold",  {31'd0, par_ready}, 32'd1);
        par_strobe = 1'b1;
        @(negedge clk);
        par_strobe = 1'b0;
        chk("ack_pulse",   {28'd0, ch_ack},    32'd1 << ch);
        chk("ack_rdy_off", {31'd0, par_ready}, 32'd0);
        if (clr) ch_full[ch] = 1'b0;
        @(negedge clk);
        chk("ack_clear",   {28'd0, ch_ack},    32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        ch_enable  = 4'b1111;
        ch_full    = 4'b0000;
        ch_data    = 32'd0;
        par_strobe = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("init_ready", {31'd0, par_ready}, 32'd0);
        chk("init_ack",   {28'd0, ch_ack},    32'd0);
        chk("init_busy",  {31'd0, busy},      32'd0);
        chk("init_grant", {30'd0, grant_ch},  32'd3);
        chk("init_data",  {24'd0, par_data},  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: idle for 20 cycles, with a stray strobe that must be ignored
        for (int i = 0; i < 20; i++) begin
            par_strobe = (i == 5);
            @(negedge clk);
            chk("idle", {25'd0, busy, par_ready, ch_ack, grant_ch}, 32'd3);
        end
        par_strobe = 1'b0;

        // 2: single request on channel 2, par_ready one cycle later
        ch_data[23:16] = 8'hA5;
        ch_full        = 4'b0100;
        @(negedge clk);
        chk("lat_ready", {31'd0, par_ready}, 32'd1);
        serve(2, 8'hA5, 1'b1);
        @(negedge clk);
        chk("post_idle", {30'd0, busy, par_ready}, 32'd0);
        ch_full = 4'b0100;
        serve(2, 8'hA5, 1'b1);

        // 3: all channels full continuously, rotation 0,1,2,3,0
        do_reset();
        ch_data = 32'h44332211;
        ch_full = 4'b1111;
        serve(0, 8'h11, 1'b0);
        serve(1, 8'h22, 1'b0);
        serve(2, 8'h33, 1'b0);
        serve(3, 8'h44, 1'b0);
        serve(0, 8'h11, 1'b0);

        // 4: channel 2 disabled, rotation 0,1,3,0,1,3
        do_reset();
        ch_enable = 4'b1011;
        serve(0, 8'h11, 1'b0);
        serve(1, 8'h22, 1'b0);
        serve(3, 8'h44, 1'b0);
        serve(0, 8'h11, 1'b0);
        serve(1, 8'h22, 1'b0);
        serve(3, 8'h44, 1'b0);

        // 5: reset mid-offer on channel 1, then channel 0 wins first
        do_reset();
        ch_enable = 4'b1111;
        ch_full   = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        chk("mid_grant", {30'd0, grant_ch}, 32'd1);
        chk("mid_ready", {31'd0, par_ready}, 32'd1);
        ch_full = 4'b0011;
        do_reset();
        serve(0, 8'h11, 1'b1);
        serve(1, 8'h22, 1'b1);

        // 6: channel 3 drops full and changes data during the offer; byte is held, grant wraps to 0
        do_reset();
        ch_data[31:24] = 8'h5C;
        ch_full        = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        chk("hold_grant", {30'd0, grant_ch}, 32'd3);
        ch_full[3]     = 1'b0;
        ch_data[31:24] = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        chk("hold_data",  {24'd0, par_data},  32'h5C);
        chk("hold_ready", {31'd0, par_ready}, 32'd1);
        serve(3, 8'h5C, 1'b1);
        ch_data[7:0] = 8'h3A;
        ch_full      = 4'b0001;
        serve(0, 8'h3A, 1'b1);
        @(negedge clk);
        chk("final_idle", {30'd0, busy, par_ready}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
